coco_eq_bus_gen: RTL

// Bus-side counterpart of the 6809E CPU core: generates the E/Q quadrature clock enables, runs one
// bus cycle per E period, and decodes the CPU address into RAM, ROM and IO selects.

---
 rtl/coco_eq_bus_gen.sv | 132 +++++++++++++
 1 files changed

// File: rtl/coco_eq_bus_gen.sv
// SAM-style bus generator for a 6809E core: E/Q enables,
// one bus cycle per E period, RAM/ROM/IO decode and strobes.
module coco_eq_bus_gen #(
  parameter int          DIV      = 4,
  parameter logic [15:0] ROM_BASE = 16'h8000,
  parameter logic [15:0] IO_BASE  = 16'hFF00
) (
  input  logic        clk,
  input  logic        reset,
  output logic        E,
  output logic        Q,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rnw,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  input  logic        cpu_ba,
  input  logic        cpu_bs,
  input  logic        halt_req,
  output logic        nHALT,
  output logic        halt_ack,
  output logic [15:0] mem_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  input  logic [7:0]  rom_rdata,
  input  logic [7:0]  io_rdata,
  output logic        io_cs,
  output logic        io_we,
  output logic        cyc_start
);

  localparam int SW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [SW-1:0] SUB_MAX = SW'(DIV - 1);

  typedef enum logic [1:0] {
    RG_RAM,
    RG_ROM,
    RG_IO
  } region_e;

  logic [SW-1:0] sub;
  logic [1:0]    qtr;
  logic [1:0]    qtr_n;
  logic          adv;
  logic          latch;
  logic          rd_ld;
  logic          efall;
  logic          rel;
  logic          live;
  logic          rnw;
  region_e       rg;
  region_e       rg_in;
  logic [7:0]    rdmux;
  logic          wr_slot;

  assign adv   = (sub == SUB_MAX);
  assign qtr_n = adv ? qtr + 2'd1 : qtr;
  assign latch = adv && (qtr == 2'd0);
  assign rd_ld = adv && (qtr == 2'd2);
  assign efall = adv && (qtr == 2'd3);
  assign rel   = cpu_ba & cpu_bs;

  always_comb begin
    rg_in = RG_RAM;
    if (cpu_addr >= IO_BASE)
      rg_in = RG_IO;
    else if (cpu_addr >= ROM_BASE)
      rg_in = RG_ROM;
  end

  always_comb begin
    rdmux = 8'hFF;
    case (rg)
      RG_RAM:  rdmux = ram_rdata;
      RG_ROM:  rdmux = rom_rdata;
      RG_IO:   rdmux = io_rdata;
      default: rdmux = 8'hFF;
    endcase
  end

  // Strobes decode straight from state so reset masks them at once.
  assign wr_slot = live && !rnw && !reset
                && (qtr == 2'd3) && adv;
  assign ram_we    = wr_slot && (rg == RG_RAM);
  assign io_we     = wr_slot && (rg == RG_IO);
  assign ram_wdata = cpu_dout;

  always_ff @(posedge clk) begin
    if (reset) begin
      sub       <= '0;
      qtr       <= 2'd0;
      E         <= 1'b0;
      Q         <= 1'b0;
      cpu_din   <= 8'hFF;
      mem_addr  <= 16'h0000;
      nHALT     <= 1'b1;
      halt_ack  <= 1'b0;
      io_cs     <= 1'b0;
      cyc_start <= 1'b0;
      live      <= 1'b0;
      rnw       <= 1'b1;
      rg        <= RG_RAM;
    end else begin
      sub       <= adv ? '0 : sub + SW'(1);
      qtr       <= qtr_n;
      Q         <= (qtr_n == 2'd1) || (qtr_n == 2'd2);
      E         <= qtr_n[1];
      nHALT     <= ~halt_req;
      cyc_start <= 1'b0;
      if (latch) begin
        live <= ~rel;
        if (!rel) begin
          mem_addr  <= cpu_addr;
          rnw       <= cpu_rnw;
          rg        <= rg_in;
          cyc_start <= 1'b1;
          io_cs     <= (rg_in == RG_IO);
        end
      end
      if (rd_ld && live && rnw)
        cpu_din <= rdmux;
      if (efall) begin
        live     <= 1'b0;
        io_cs    <= 1'b0;
        halt_ack <= rel & halt_req;
      end else if (!halt_req) begin
        halt_ack <= 1'b0;
      end
    end
  end

endmodule
